// File: rtl/quadrature_pkg.sv
// -----------------------------------------------------------------------------
// quadrature_pkg
// Shared types and constants for the quadrature encoder emulator.
//   state_t  : IDLE / STEP / FINISH controller states
//   dir_t    : rotation direction (DIR_CW / DIR_CCW)
//   AB_CW    : AB sequence of one clockwise detent, index 0 is driven first
//   AB_CCW   : AB sequence of one counter-clockwise detent
//   POS_MIN  : lowest detent position
// AB values are packed as {A, B}.
// -----------------------------------------------------------------------------
package quadrature_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef enum logic {
        DIR_CW  = 1'b0,
        DIR_CCW = 1'b1
    } dir_t;

    // Element [0] is the first phase after rest (00); element [3] returns to 00.
    // CW : 10, 11, 01, 00   (A leads, so A rises while B=0)
    // CCW: 01, 11, 10, 00   (B leads, so A rises while B=1)
    localparam logic [3:0][1:0] AB_CW  = {2'b00, 2'b01, 2'b11, 2'b10};
    localparam logic [3:0][1:0] AB_CCW = {2'b00, 2'b10, 2'b11, 2'b01};

    localparam int POS_MIN = 1;

    function automatic logic [1:0] ab_phase(input dir_t d, input logic [1:0] idx);
        return (d == DIR_CW) ? AB_CW[idx] : AB_CCW[idx];
    endfunction

endpackage

// File: rtl/quadrature_emulator_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter. Loading N makes o_tick assert during the N-th cycle
// after the load edge, so logic acting on o_tick fires exactly N edges after
// the load. The counter stops at zero unless reloaded.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   i_load   : load i_value this edge (priority over counting)
//   i_value  : reload value, 1 or more
//   o_tick   : terminal-count pulse
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_tick
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tick = (r_count == W'(1));

endmodule

// File: rtl/quadrature_emulator.sv
// -----------------------------------------------------------------------------
// quadrature_emulator
// Drives rotary-encoder quadrature lines (A/B) and a push-button line so that
// the encoder reader ends up at a commanded detent position (1..NUM_POS).
// Optional build macro: SHORTEST_PATH_EN -- when defined, moves longer than
// half a turn are done counter-clockwise; otherwise every move is clockwise.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   cmd_valid/ready : target handshake, ready only while idle
//   cmd_target      : requested position
//   cmd_error       : one-cycle pulse for an out-of-range target
//   btn_req         : single-cycle button press request
//   signal_a/b      : quadrature outputs (registered)
//   button          : emulated button level
//   position        : position the decoder is believed to hold
//   busy            : stepping in progress
//   done            : one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module quadrature_emulator
    import quadrature_pkg::*;
#(
    parameter int PHASE_CYCLES  = 1000,
    parameter int BUTTON_CYCLES = 50000,
    parameter int POS_W         = 4,
    parameter int NUM_POS       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_target,
    output logic             cmd_error,
    input  logic             btn_req,
    output logic             signal_a,
    output logic             signal_b,
    output logic             button,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done
);

    localparam int PW = $clog2(PHASE_CYCLES + 1);
    localparam int BW = $clog2(BUTTON_CYCLES + 1);

    localparam logic [PW-1:0]    PH_ONE   = PW'(1);
    localparam logic [PW-1:0]    PH_FULL  = PW'(PHASE_CYCLES);
    // The last 00 hold is one cycle shorter because FINISH adds the final cycle.
    localparam logic [PW-1:0]    PH_LAST  = PW'(PHASE_CYCLES - 1);
    localparam logic [BW-1:0]    BTN_FULL = BW'(BUTTON_CYCLES);
    localparam logic [POS_W-1:0] POS_LO   = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] POS_HI   = POS_W'(NUM_POS);
    localparam logic [POS_W:0]   FWD_NUM  = (POS_W+1)'(NUM_POS);
    localparam logic [POS_W:0]   FWD_HALF = (POS_W+1)'(NUM_POS / 2);

    state_t           r_state;
    dir_t             r_dir;
    logic [1:0]       r_phase;
    logic [POS_W:0]   r_steps;
    logic [1:0]       r_ab;
    logic [POS_W-1:0] r_position;
    logic             r_busy;
    logic             r_done;
    logic             r_cmd_error;
    logic             r_button;

    logic             w_target_ok;
    logic [POS_W:0]   w_diff;
    logic [POS_W:0]   w_fwd;
    dir_t             w_dir;
    logic [POS_W:0]   w_steps;
    logic             w_start;
    logic             w_advance;
    logic             w_last;
    logic [1:0]       w_ab_next;
    logic [POS_W-1:0] w_pos_stepped;
    logic             w_phase_load;
    logic [PW-1:0]    w_phase_value;
    logic             w_phase_tick;
    logic             w_btn_load;
    logic             w_btn_tick;

    assign w_target_ok = (cmd_target >= POS_LO) && (cmd_target <= POS_HI);

    // Signed difference in POS_W+1 bits; a negative result wraps by NUM_POS.
    assign w_diff = {1'b0, cmd_target} - {1'b0, r_position};
    assign w_fwd  = w_diff[POS_W] ? (w_diff + FWD_NUM) : w_diff;

    always_comb begin
        w_dir   = DIR_CW;
        w_steps = w_fwd;
`ifdef SHORTEST_PATH_EN
        if (w_fwd > FWD_HALF) begin
            w_dir   = DIR_CCW;
            w_steps = FWD_NUM - w_fwd;
        end
`endif
    end

    assign w_start   = (r_state == IDLE) && cmd_valid && w_target_ok && (w_fwd != '0);
    // r_steps reaching zero means the final 00 hold has expired.
    assign w_advance = (r_state == STEP) && w_phase_tick && (r_steps != '0);
    assign w_last    = (r_phase == 2'd3) && (r_steps == (POS_W+1)'(1));
    assign w_ab_next = ab_phase(r_dir, r_phase);

    always_comb begin
        w_pos_stepped = r_position + 1'b1;
        if (r_dir == DIR_CW) begin
            if (r_position == POS_HI) w_pos_stepped = POS_LO;
        end else begin
            w_pos_stepped = (r_position == POS_LO) ? POS_HI : (r_position - 1'b1);
        end
    end

    assign w_phase_load  = w_start || (w_advance && !(w_last && PHASE_CYCLES == 1));
    assign w_phase_value = w_start ? PH_ONE : (w_last ? PH_LAST : PH_FULL);

    phase_timer #(.W(PW)) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_phase_load),
        .i_value (w_phase_value),
        .o_tick  (w_phase_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dir       <= DIR_CW;
            r_phase     <= 2'd0;
            r_steps     <= '0;
            r_ab        <= 2'b00;
            r_position  <= POS_LO;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_error <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_cmd_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (!w_target_ok) begin
                            r_cmd_error <= 1'b1;
                        end else if (w_fwd == '0) begin
                            r_state <= FINISH;
                        end else begin
                            r_dir   <= w_dir;
                            r_steps <= w_steps;
                            r_phase <= 2'd0;
                            r_busy  <= 1'b1;
                            r_state <= STEP;
                        end
                    end
                end
                STEP: begin
                    if (w_phase_tick && (r_steps == '0)) begin
                        r_state <= FINISH;
                    end else if (w_advance) begin
                        r_ab    <= w_ab_next;
                        r_phase <= r_phase + 2'd1;
                        // The decoder counts on the A rising edge, so position follows it.
                        if (w_ab_next[1] && !r_ab[1]) begin
                            r_position <= w_pos_stepped;
                        end
                        if (r_phase == 2'd3) begin
                            r_steps <= r_steps - 1'b1;
                        end
                        if (w_last && PHASE_CYCLES == 1) begin
                            r_state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Button path runs independently of the stepping controller.
    assign w_btn_load = btn_req && !r_button;

    phase_timer #(.W(BW)) u_button_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_btn_load),
        .i_value (BTN_FULL),
        .o_tick  (w_btn_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_button <= 1'b0;
        end else if (w_btn_load) begin
            r_button <= 1'b1;
        end else if (w_btn_tick) begin
            r_button <= 1'b0;
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign cmd_error = r_cmd_error;
    assign signal_a  = r_ab[1];
    assign signal_b  = r_ab[0];
    assign button    = r_button;
    assign position  = r_position;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_quadrature_emulator.sv
// -----------------------------------------------------------------------------
// tb_quadrature_emulator
// Self-checking bench for quadrature_emulator with PHASE_CYCLES=4 and
// BUTTON_CYCLES=10. Expected moves are derived from modular position
// arithmetic; the AB stream is watched cycle by cycle for single-bit
// transitions, hold times, A rising edges and the decoded position.
// -----------------------------------------------------------------------------
module tb_quadrature_emulator;

    localparam int P       = 4;
    localparam int BC      = 10;
    localparam int POS_W   = 4;
    localparam int NUM_POS = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [POS_W-1:0] cmd_target = '0;
    logic             btn_req = 1'b0;
    logic             cmd_ready;
    logic             cmd_error;
    logic             signal_a;
    logic             signal_b;
    logic             button;
    logic [POS_W-1:0] position;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;
    int model_pos = 1;

    always #5 clk = ~clk;

    quadrature_emulator #(
        .PHASE_CYCLES  (P),
        .BUTTON_CYCLES (BC),
        .POS_W         (POS_W),
        .NUM_POS       (NUM_POS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_error  (cmd_error),
        .btn_req    (btn_req),
        .signal_a   (signal_a),
        .signal_b   (signal_b),
        .button     (button),
        .position   (position),
        .busy       (busy),
        .done       (done)
    );

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_timeout: cmd_ready=%b want 1", nm, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({signal_a, signal_b, button, busy, done, cmd_error} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: a,b,btn,busy,done,err=%b want 000000",
                     {signal_a, signal_b, button, busy, done, cmd_error});
        end
        total++;
        if (position !== 4'd1) begin
            bad++;
            $display("FAIL reset_position: got %0d want 1", position);
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        rst = 1'b0;
        model_pos = 1;
        $display("reset: position=%0d ready=%b", position, cmd_ready);
    endtask

    // One positioning command, fully monitored until done.
    task automatic do_move(input int tgt, input string nm);
        int fwd, steps, exp_done, k, rises, last_chg, done_k, pexp;
        bit cw, busy_seen;
        logic [1:0] prev, cur;
        string dname;

        fwd = (((tgt - model_pos) % NUM_POS) + NUM_POS) % NUM_POS;
`ifdef SHORTEST_PATH_EN
        cw = (fwd <= NUM_POS / 2);
`else
        cw = 1'b1;
`endif
        steps    = cw ? fwd : (NUM_POS - fwd);
        exp_done = 1 + steps * 4 * P;
        dname    = cw ? "cw" : "ccw";

        wait_ready(nm);
        prev       = {signal_a, signal_b};
        cmd_target = POS_W'(tgt);
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;

        rises = 0; last_chg = 0; done_k = -1; pexp = model_pos; busy_seen = 1'b0;
        for (k = 0; k <= exp_done + 8 && done_k < 0; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            cur = {signal_a, signal_b};
            if (busy === 1'b1) busy_seen = 1'b1;
            if (cur !== prev) begin
                total++;
                if (!((cur ^ prev) == 2'b01 || (cur ^ prev) == 2'b10)) begin
                    bad++;
                    $display("FAIL %s gray_step: %b -> %b at cycle %0d", nm, prev, cur, k);
                end
                total++;
                if ((k - last_chg) != ((last_chg == 0) ? 1 : P)) begin
                    bad++;
                    $display("FAIL %s phase_hold: change at cycle %0d after %0d, want gap %0d",
                             nm, k, last_chg, (last_chg == 0) ? 1 : P);
                end
                if (cur[1] && !prev[1]) begin
                    rises++;
                    pexp = cw ? ((pexp % NUM_POS) + 1) : ((pexp == 1) ? NUM_POS : pexp - 1);
                    total++;
                    if (cur[0] !== (cw ? 1'b0 : 1'b1)) begin
                        bad++;
                        $display("FAIL %s b_at_a_rise: got %b want %b", nm, cur[0], !cw);
                    end
                    total++;
                    if (position !== POS_W'(pexp)) begin
                        bad++;
                        $display("FAIL %s position_at_rise: got %0d want %0d", nm, position, pexp);
                    end
                end
                last_chg = k;
                prev = cur;
            end
            if (done === 1'b1) done_k = k;
        end

        total++;
        if (done_k != exp_done) begin
            bad++;
            $display("FAIL %s done_cycle: got %0d want %0d", nm, done_k, exp_done);
        end
        total++;
        if (rises != steps) begin
            bad++;
            $display("FAIL %s a_rises: got %0d want %0d", nm, rises, steps);
        end
        total++;
        if (position !== POS_W'(tgt)) begin
            bad++;
            $display("FAIL %s final_position: got %0d want %0d", nm, position, tgt);
        end
        total++;
        if ({signal_a, signal_b} !== 2'b00) begin
            bad++;
            $display("FAIL %s final_ab: got %b want 00", nm, {signal_a, signal_b});
        end
        total++;
        if (busy_seen != (steps > 0)) begin
            bad++;
            $display("FAIL %s busy_seen: got %0d want %0d", nm, busy_seen, steps > 0);
        end
        @(posedge clk); #1;
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL %s done_pulse: done,busy=%b want 00", nm, {done, busy});
        end
        $display("move %s: from=%0d target=%0d dir=%s steps=%0d done_at=%0d",
                 nm, model_pos, tgt, dname, steps, done_k);
        model_pos = tgt;
    endtask

    task automatic test_error(input int tgt, input string nm);
        wait_ready(nm);
        cmd_target = POS_W'(tgt);
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        total++;
        if (cmd_error !== 1'b1) begin
            bad++;
            $display("FAIL %s error_pulse: got %b want 1", nm, cmd_error);
        end
        total++;
        if ({cmd_ready, busy, signal_a, signal_b} !== 4'b1000) begin
            bad++;
            $display("FAIL %s error_state: ready,busy,a,b=%b want 1000", nm,
                     {cmd_ready, busy, signal_a, signal_b});
        end
        total++;
        if (position !== POS_W'(model_pos)) begin
            bad++;
            $display("FAIL %s error_position: got %0d want %0d", nm, position, model_pos);
        end
        @(posedge clk); #1;
        total++;
        if ({cmd_error, done, cmd_ready} !== 3'b001) begin
            bad++;
            $display("FAIL %s error_after: err,done,ready=%b want 001", nm,
                     {cmd_error, done, cmd_ready});
        end
        $display("error %s: target=%0d position=%0d", nm, tgt, position);
    endtask

    task automatic test_reset_mid_step();
        int k, tgt;
        tgt = ((model_pos + 1) % NUM_POS) + 1;
        wait_ready("mid_reset");
        cmd_target = POS_W'(tgt);
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        k = 0;
        while ({signal_a, signal_b} !== 2'b11 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if ({signal_a, signal_b} !== 2'b11) begin
            bad++;
            $display("FAIL mid_reset reach_11: ab=%b want 11", {signal_a, signal_b});
        end
        rst = 1'b1;
        #1;
        total++;
        if ({signal_a, signal_b, busy} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset async_clear: a,b,busy=%b want 000", {signal_a, signal_b, busy});
        end
        total++;
        if (position !== 4'd1) begin
            bad++;
            $display("FAIL mid_reset position: got %0d want 1", position);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_pos = 1;
        $display("reset mid-step: ab=%b position=%0d", {signal_a, signal_b}, position);
        do_move(4, "after_reset");
    endtask

    task automatic button_seq();
        int hi, rises;
        logic prevb;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (button !== 1'b0) begin
            bad++;
            $display("FAIL button_idle: got %b want 0", button);
        end
        btn_req = 1'b1;
        hi = 0; rises = 0; prevb = button;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (i == 0) btn_req = 1'b0;
            if (i == 2) btn_req = 1'b1;
            if (i == 3) btn_req = 1'b0;
            if (i == 0) begin
                total++;
                if (button !== 1'b1) begin
                    bad++;
                    $display("FAIL button_rise: got %b want 1", button);
                end
            end
            if (button === 1'b1) hi++;
            if (button === 1'b1 && prevb !== 1'b1) rises++;
            prevb = button;
        end
        total++;
        if (hi != BC) begin
            bad++;
            $display("FAIL button_width: got %0d want %0d", hi, BC);
        end
        total++;
        if (rises != 1) begin
            bad++;
            $display("FAIL button_retrigger: rises %0d want 1", rises);
        end
        $display("button: high_cycles=%0d rises=%0d", hi, rises);
    endtask

    task automatic test_button_during_step();
        int tgt;
        tgt = ((model_pos + 1) % NUM_POS) + 1;
        fork
            do_move(tgt, "with_button");
            button_seq();
        join
    endtask

    task automatic test_random();
        int tgt;
        for (int n = 0; n < 8; n++) begin
            tgt = $urandom_range(1, NUM_POS);
            do_move(tgt, "random");
        end
    endtask

    initial begin
        test_reset();
        do_move(3, "basic");
        do_move(1, "back");
        do_move(8, "wrap");
        do_move(5, "to5");
        do_move(5, "same");
        test_error(0, "zero");
        test_error(9, "nine");
        test_error(15, "fifteen");
        test_reset_mid_step();
        test_button_during_step();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
